// File: rtl/score_display_pkg.sv
// score_display_pkg: scan FSM state encoding and 7-segment code table
package score_display_pkg;
  // Encoding chosen so the scan order is a plain 2-bit increment
  typedef enum logic [1:0] {
    SHOW_L  = 2'd0,
    BLANK_L = 2'd1,
    SHOW_H  = 2'd2,
    BLANK_H = 2'd3
  } state_t;
  localparam logic [0:9][6:0] SEG_TAB = {
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };
  localparam logic [6:0] SEG_DASH = 7'h40;
endpackage

// File: rtl/score_display_bcd_to_seg7.sv
// bcd_to_seg7: combinational BCD to 7-segment {g,f,e,d,c,b,a} decoder
//   bcd  in  4  digit value; 10-15 show a dash
//   seg  out 7  active-high segments
module bcd_to_seg7
  import score_display_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);
  assign seg = (bcd > 4'd9) ? SEG_DASH : SEG_TAB[bcd];
endmodule

// File: rtl/score_display.sv
// score_display: two-digit multiplexed 7-segment scanner with blanking gaps
//   I_clk   in  1  clock
//   I_rst   in  1  async active-high reset
//   I_bcd   in  8  score {tens, units}, captured once per frame
//   I_mode  in  1  counter mode, shown on the units decimal point
//   O_seg   out 7  segments {g,f,e,d,c,b,a}
//   O_dp    out 1  decimal point
//   O_an    out 2  digit enables {tens, units}
// Define SCORE_DISPLAY_LZB_EN to blank a leading zero tens digit.
module score_display
  import score_display_pkg::*;
#(
  parameter int SHOW_CYC  = 50000,
  parameter int BLANK_CYC = 500
) (
  input  logic       I_clk,
  input  logic       I_rst,
  input  logic [7:0] I_bcd,
  input  logic       I_mode,
  output logic [6:0] O_seg,
  output logic       O_dp,
  output logic [1:0] O_an
);
  localparam int MAXC = (SHOW_CYC > BLANK_CYC) ? SHOW_CYC : BLANK_CYC;
  localparam int W = $clog2(MAXC) + 1;
  localparam logic [W-1:0] SHOW_LAST  = W'(SHOW_CYC - 1);
  localparam logic [W-1:0] BLANK_LAST = W'(BLANK_CYC - 1);
`ifdef SCORE_DISPLAY_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif
  state_t     state, nxt;
  logic [W-1:0] cnt, cnt_nxt;
  logic [7:0] bcd, bcd_nxt;
  logic       mode, mode_nxt;
  logic       last, cap, hide, dp_nxt;
  logic [3:0] dig;
  logic [6:0] dec, seg_nxt;
  logic [1:0] an_nxt;
  bcd_to_seg7 u_dec (.bcd(dig), .seg(dec));
  // Outputs are computed from the next state and next frame values so they
  // land on the same edge as the state register.
  always_comb begin
    last     = cnt == ((state == SHOW_L || state == SHOW_H) ? SHOW_LAST : BLANK_LAST);
    nxt      = last ? state_t'(state + 2'd1) : state;
    cnt_nxt  = last ? '0 : cnt + 1'b1;
    cap      = last && state == BLANK_H;
    bcd_nxt  = cap ? I_bcd : bcd;
    mode_nxt = cap ? I_mode : mode;
    dig      = (nxt == SHOW_H) ? bcd_nxt[7:4] : bcd_nxt[3:0];
    hide     = LZB && nxt == SHOW_H && bcd_nxt[7:4] == 4'd0;
    an_nxt   = hide ? 2'b00 : (nxt == SHOW_L) ? 2'b01 : (nxt == SHOW_H) ? 2'b10 : 2'b00;
    seg_nxt  = (an_nxt != 2'b00) ? dec : 7'd0;
    dp_nxt   = nxt == SHOW_L && mode_nxt;
  end
  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      state <= BLANK_H;
      cnt   <= '0;
      bcd   <= '0;
      mode  <= 1'b0;
      O_seg <= '0;
      O_dp  <= 1'b0;
      O_an  <= '0;
    end else begin
      state <= nxt;
      cnt   <= cnt_nxt;
      bcd   <= bcd_nxt;
      mode  <= mode_nxt;
      O_seg <= seg_nxt;
      O_dp  <= dp_nxt;
      O_an  <= an_nxt;
    end
  end
endmodule

// File: tb/tb_score_display.sv
// tb_score_display: directed self-checking bench for score_display (SHOW=8, BLANK=2)
module tb_score_display;
  logic       I_clk = 1'b0;
  logic       I_rst = 1'b1;
  logic [7:0] I_bcd = 8'h00;
  logic       I_mode = 1'b0;
  logic [6:0] O_seg;
  logic       O_dp;
  logic [1:0] O_an;
  int checks = 0;
  int errors = 0;
  int ph = 18;
  logic [7:0] cap_bcd = 8'h00;
  logic       cap_mode = 1'b0;
  logic [1:0] prev_an = 2'b00;
  score_display #(.SHOW_CYC(8), .BLANK_CYC(2)) dut (
    .I_clk(I_clk), .I_rst(I_rst), .I_bcd(I_bcd), .I_mode(I_mode),
    .O_seg(O_seg), .O_dp(O_dp), .O_an(O_an)
  );
  always #5 I_clk = ~I_clk;
  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'd0: return 7'h3F;
      4'd1: return 7'h06;
      4'd2: return 7'h5B;
      4'd3: return 7'h4F;
      4'd4: return 7'h66;
      4'd5: return 7'h6D;
      4'd6: return 7'h7D;
      4'd7: return 7'h07;
      4'd8: return 7'h7F;
      4'd9: return 7'h6F;
      default: return 7'h40;
    endcase
  endfunction
  // Frame phase p: 0-7 SHOW_L, 8-9 BLANK_L, 10-17 SHOW_H, 18-19 BLANK_H
  function automatic logic [9:0] exp_out(input int p);
    if (p < 8) return {2'b01, cap_mode, seg7(cap_bcd[3:0])};
    if (p >= 10 && p < 18) begin
`ifdef SCORE_DISPLAY_LZB_EN
      if (cap_bcd[7:4] == 4'd0) return 10'd0;
`endif
      return {2'b10, 1'b0, seg7(cap_bcd[7:4])};
    end
    return 10'd0;
  endfunction
  task automatic step();
    @(negedge I_clk);
    ph = (ph + 1) % 20;
    if (ph == 0) begin
      cap_bcd  = I_bcd;
      cap_mode = I_mode;
    end
  endtask
  task automatic advance_to(input int p);
    step();
    while (ph != p) step();
  endtask
  always @(negedge I_clk) begin
    checks++;
    if (O_an === 2'b11 || (prev_an != 2'b00 && O_an != 2'b00 && O_an !== prev_an)) begin
      errors++;
      $display("FAIL an_guard t=%0t prev=%b got=%b required no 11 and blank between digits", $time, prev_an, O_an);
    end
    prev_an = O_an;
  end
  task automatic test_reset();
    I_rst = 1'b1;
    I_bcd = 8'h00;
    I_mode = 1'b0;
    repeat (2) @(negedge I_clk);
    checks++;
    if ({O_an, O_dp, O_seg} !== 10'd0) begin
      errors++;
      $display("FAIL reset_hold got=%h required=000", {O_an, O_dp, O_seg});
    end
    I_rst = 1'b0;
    ph = 18;
    cap_bcd = 8'h00;
    cap_mode = 1'b0;
    for (int i = 1; i <= 22; i++) begin
      step();
      checks++;
      if ({O_an, O_dp, O_seg} !== exp_out(ph)) begin
        errors++;
        $display("FAIL reset_frame cyc=%0d got=%h required=%h", i, {O_an, O_dp, O_seg}, exp_out(ph));
      end
      if (i == 2) begin
        checks++;
        if (O_an !== 2'b01 || O_seg !== 7'h3F) begin
          errors++;
          $display("FAIL first_show_l an=%b seg=%h required an=01 seg=3f", O_an, O_seg);
        end
      end
    end
  endtask
  task automatic test_mode_digits();
    I_bcd = 8'h47;
    I_mode = 1'b1;
    advance_to(0);
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if ({O_an, O_dp, O_seg} !== exp_out(ph)) begin
        errors++;
        $display("FAIL mode_frame ph=%0d got=%h required=%h", ph, {O_an, O_dp, O_seg}, exp_out(ph));
      end
      if (i < 19 && ph == 3) begin
        checks++;
        if (O_seg !== 7'h07 || O_dp !== 1'b1) begin
          errors++;
          $display("FAIL units_47 seg=%h dp=%b required seg=07 dp=1", O_seg, O_dp);
        end
      end
      if (ph == 12) begin
        checks++;
        if (O_seg !== 7'h66 || O_dp !== 1'b0 || O_an !== 2'b10) begin
          errors++;
          $display("FAIL tens_47 seg=%h dp=%b an=%b required seg=66 dp=0 an=10", O_seg, O_dp, O_an);
        end
      end
    end
  endtask
  task automatic test_no_tear();
    I_bcd = 8'h12;
    I_mode = 1'b0;
    advance_to(0);
    advance_to(4);
    I_bcd = 8'h99;
    for (int i = 0; i < 35; i++) begin
      step();
      checks++;
      if ({O_an, O_dp, O_seg} !== exp_out(ph)) begin
        errors++;
        $display("FAIL tear_frame ph=%0d got=%h required=%h", ph, {O_an, O_dp, O_seg}, exp_out(ph));
      end
      if (i < 15 && (ph == 5 || ph == 12)) begin
        checks++;
        if (O_seg !== (ph == 5 ? 7'h5B : 7'h06)) begin
          errors++;
          $display("FAIL no_tear ph=%0d seg=%h required=%h", ph, O_seg, ph == 5 ? 7'h5B : 7'h06);
        end
      end
      if (i >= 15 && (ph == 2 || ph == 12)) begin
        checks++;
        if (O_seg !== 7'h6F) begin
          errors++;
          $display("FAIL next_frame_99 ph=%0d seg=%h required=6f", ph, O_seg);
        end
      end
    end
  endtask
  task automatic test_dash();
    I_bcd = 8'hA5;
    advance_to(0);
    for (int i = 0; i < 19; i++) begin
      step();
      checks++;
      if ({O_an, O_dp, O_seg} !== exp_out(ph)) begin
        errors++;
        $display("FAIL dash_frame ph=%0d got=%h required=%h", ph, {O_an, O_dp, O_seg}, exp_out(ph));
      end
      if (ph == 1 || ph == 10) begin
        checks++;
        if (O_seg !== (ph == 1 ? 7'h6D : 7'h40)) begin
          errors++;
          $display("FAIL dash_a5 ph=%0d seg=%h required=%h", ph, O_seg, ph == 1 ? 7'h6D : 7'h40);
        end
      end
    end
  endtask
  task automatic test_lzb();
    I_bcd = 8'h05;
    advance_to(0);
    for (int i = 0; i < 19; i++) begin
      step();
      checks++;
      if ({O_an, O_dp, O_seg} !== exp_out(ph)) begin
        errors++;
        $display("FAIL lzb_frame ph=%0d got=%h required=%h", ph, {O_an, O_dp, O_seg}, exp_out(ph));
      end
      if (ph >= 10 && ph < 18) begin
        checks++;
`ifdef SCORE_DISPLAY_LZB_EN
        if (O_an !== 2'b00 || O_seg !== 7'h00) begin
          errors++;
          $display("FAIL lzb_tens ph=%0d an=%b seg=%h required an=00 seg=00", ph, O_an, O_seg);
        end
`else
        if (O_an !== 2'b10 || O_seg !== 7'h3F) begin
          errors++;
          $display("FAIL zero_tens ph=%0d an=%b seg=%h required an=10 seg=3f", ph, O_an, O_seg);
        end
`endif
      end
    end
  endtask
  task automatic test_reset_mid();
    I_bcd = 8'h36;
    advance_to(12);
    #2 I_rst = 1'b1;
    #1;
    checks++;
    if ({O_an, O_dp, O_seg} !== 10'd0) begin
      errors++;
      $display("FAIL async_blank got=%h required=000", {O_an, O_dp, O_seg});
    end
    @(negedge I_clk);
    I_rst = 1'b0;
    ph = 18;
    cap_bcd = 8'h00;
    cap_mode = 1'b0;
    for (int i = 1; i <= 22; i++) begin
      step();
      checks++;
      if ({O_an, O_dp, O_seg} !== exp_out(ph)) begin
        errors++;
        $display("FAIL restart_frame cyc=%0d got=%h required=%h", i, {O_an, O_dp, O_seg}, exp_out(ph));
      end
      if (i <= 2) begin
        checks++;
        if (O_an !== (i == 1 ? 2'b00 : 2'b01) || (i == 2 && O_seg !== 7'h7D)) begin
          errors++;
          $display("FAIL restart_edge cyc=%0d an=%b seg=%h", i, O_an, O_seg);
        end
      end
    end
  endtask
  initial begin
    test_reset();
    test_mode_digits();
    test_no_tear();
    test_dash();
    test_lzb();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
